// File: rtl/bufft_toggle_arbiter_pkg.sv
// bufft_toggle_arbiter_pkg: shared FSM state type, pointer-width helper and flip counter width (package bufft_arb_pkg)
package bufft_arb_pkg;
  typedef enum logic [1:0] {INIT, IDLE, GUARD} arb_state_t;
  localparam int CNT_W = 16;
  function automatic int idx_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bufft_toggle_arbiter_if.sv
// bufft_toggle_arbiter_if: request/grant bundle (req, ack, q, q_pulse, ready, flip_cnt when BUFFT_ARB_CNT_EN); master = requesters, slave = arbiter
interface bufft_toggle_arbiter_if import bufft_arb_pkg::*; #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic q;
  logic q_pulse;
  logic ready;
`ifdef BUFFT_ARB_CNT_EN
  logic [CNT_W-1:0] flip_cnt;
  modport master(output req, input ack, q, q_pulse, ready, flip_cnt);
  modport slave(input req, output ack, q, q_pulse, ready, flip_cnt);
`else
  modport master(output req, input ack, q, q_pulse, ready);
  modport slave(input req, output ack, q, q_pulse, ready);
`endif
endinterface

// File: rtl/bufft_toggle_arbiter_rr_pick.sv
// bufft_rr_pick: combinational rotating-priority picker; req/ptr in, valid/idx of first set bit above ptr (wrapping) out
module bufft_rr_pick import bufft_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic             valid,
  output logic [W-1:0]     idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % N_REQ]) begin
        valid = 1'b1;
        idx = W'((int'(ptr) + k) % N_REQ);
      end
  end
endmodule

// File: rtl/bufft_toggle_arbiter.sv
// bufft_toggle_arbiter: round-robin grant of one toggle line; clk, rst, bus (slave: req in; ack, q, q_pulse, ready, flip_cnt under BUFFT_ARB_CNT_EN out)
module bufft_toggle_arbiter import bufft_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int GUARD_CYC = 2,
  parameter int BEGIN_CYC = 8
) (
  input logic clk,
  input logic rst,
  bufft_toggle_arbiter_if.slave bus
);
  localparam int W = idx_w(N_REQ);
  localparam logic [7:0] BEGIN_LD = 8'(BEGIN_CYC - 1);
  localparam logic [7:0] GUARD_LD = 8'(GUARD_CYC == 0 ? 0 : GUARD_CYC - 1);
  localparam logic [N_REQ-1:0] ONE = 1;
  arb_state_t state;
  logic [7:0] cnt;
  logic [W-1:0] ptr, pick;
  logic valid, grant;
  // a requester whose ack is still high has not had a chance to drop req yet
  bufft_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req & ~bus.ack),
    .ptr(ptr),
    .valid(valid),
    .idx(pick)
  );
  assign grant = state == IDLE && valid;
  // cnt serves both the startup blackout and the post-flip guard
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      cnt <= BEGIN_LD;
      ptr <= W'(N_REQ - 1);
      bus.ack <= '0;
      bus.q <= 1'b0;
      bus.q_pulse <= 1'b0;
      bus.ready <= 1'b0;
    end else begin
      bus.ack <= grant ? ONE << pick : '0;
      bus.q_pulse <= grant;
      if (grant) begin
        bus.q <= ~bus.q;
        ptr <= pick;
      end
      if (state != IDLE) begin
        if (cnt == 0) begin
          state <= IDLE;
          bus.ready <= 1'b1;
        end else cnt <= cnt - 1'b1;
      end else if (grant && GUARD_CYC != 0) begin
        state <= GUARD;
        cnt <= GUARD_LD;
        bus.ready <= 1'b0;
      end
    end
`ifdef BUFFT_ARB_CNT_EN
  always_ff @(posedge clk)
    if (rst) bus.flip_cnt <= '0;
    else if (grant) bus.flip_cnt <= bus.flip_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_bufft_toggle_arbiter.sv
// tb_bufft_toggle_arbiter: table-driven check of blackout, round-robin, drop, reset-in-guard; hand sequences for zero-guard and flip counter
module tb_bufft_toggle_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  bufft_toggle_arbiter_if #(.N_REQ(4)) ia ();
  bufft_toggle_arbiter_if #(.N_REQ(4)) ib ();
  bufft_toggle_arbiter #(.N_REQ(4), .GUARD_CYC(2), .BEGIN_CYC(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  bufft_toggle_arbiter #(.N_REQ(4), .GUARD_CYC(0), .BEGIN_CYC(8)) dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic q;
    logic p;
    logic rdy;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ak, input logic q, input logic p, input logic rd);
    vec_t v;
    v.rst = r; v.req = rq; v.ack = ak; v.q = q; v.p = p; v.rdy = rd;
    tv.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic step_b(input string name, input logic [3:0] ak, input logic q, input logic p, input logic rd);
    @(posedge clk);
    #1;
    chk({name, ".ack"}, 32'(ib.ack), 32'(ak));
    chk({name, ".q"}, 32'(ib.q), 32'(q));
    chk({name, ".pulse"}, 32'(ib.q_pulse), 32'(p));
    chk({name, ".ready"}, 32'(ib.ready), 32'(rd));
  endtask
  initial begin
    logic qv;
    ia.req = '0;
    ib.req = '0;
    add(1, 4'h0, 4'h0, 0, 0, 0);
    repeat (7) add(0, 4'h1, 4'h0, 0, 0, 0);
    add(0, 4'h1, 4'h0, 0, 0, 1);
    add(0, 4'h1, 4'h1, 1, 1, 0);
    qv = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      add(0, 4'hf, 4'h0, qv, 0, 0);
      add(0, 4'hf, 4'h0, qv, 0, 1);
      qv = ~qv;
      add(0, 4'hf, 4'h1 << (k % 4), qv, 1, 0);
    end
    add(0, 4'h2, 4'h0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0, 1);
    add(0, 4'h0, 4'h0, 1, 0, 1);
    add(0, 4'h4, 4'h4, 0, 1, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 1);
    add(0, 4'h8, 4'h8, 1, 1, 0);
    add(1, 4'h0, 4'h0, 0, 0, 0);
    repeat (7) add(0, 4'h1, 4'h0, 0, 0, 0);
    add(0, 4'h1, 4'h0, 0, 0, 1);
    add(0, 4'hf, 4'h1, 1, 1, 0);
    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      rst = tv[i].rst;
      ia.req = tv[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ack", i), 32'(ia.ack), 32'(tv[i].ack));
      chk($sformatf("v%0d.q", i), 32'(ia.q), 32'(tv[i].q));
      chk($sformatf("v%0d.pulse", i), 32'(ia.q_pulse), 32'(tv[i].p));
      chk($sformatf("v%0d.ready", i), 32'(ia.ready), 32'(tv[i].rdy));
    end
    ia.req = '0;
    rst_b = 1'b0;
    repeat (7) step_b("b_blk", 4'h0, 0, 0, 0);
    step_b("b_open", 4'h0, 0, 0, 1);
    ib.req = 4'h4;
    step_b("b2_a", 4'h4, 1, 1, 1);
    step_b("b2_mask", 4'h0, 1, 0, 1);
    step_b("b2_c", 4'h4, 0, 1, 1);
    ib.req = 4'h0;
    step_b("b2_drop", 4'h0, 0, 0, 1);
    ib.req = 4'h3;
    step_b("b01_a", 4'h1, 1, 1, 1);
    step_b("b01_b", 4'h2, 0, 1, 1);
    step_b("b01_c", 4'h1, 1, 1, 1);
    ib.req = 4'h0;
    step_b("b01_idle", 4'h0, 1, 0, 1);
`ifdef BUFFT_ARB_CNT_EN
    chk("cnt_five", 32'(ib.flip_cnt), 32'd5);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("cnt_rst", 32'(ib.flip_cnt), 32'd0);
    rst_b = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    ib.req = 4'h3;
    repeat (65537) @(posedge clk);
    #1;
    ib.req = 4'h0;
    chk("cnt_wrap", 32'(ib.flip_cnt), 32'd1);
    chk("cnt_wrap_q", 32'(ib.q), 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
